// File: rtl/door_access_scheduler.sv
// Door access scheduler: debounces the local/remote buttons, arbitrates them (and the auto-close
// timer) onto the single Activate pulse, then supervises motor travel. Auto-close: AUTO_CLOSE_EN.
module door_access_scheduler #(
    parameter int DEB_CYCLES     = 4,
    parameter int START_WIN      = 3,
    parameter int TIMEOUT_CYC    = 32,
    parameter int AUTO_CLOSE_CYC = 16,
    parameter int CNT_W          = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_btn_local,
    input  logic       i_btn_remote,
    input  logic       i_up_max,
    input  logic       i_down_max,
    input  logic       i_up_m,
    input  logic       i_down_m,
    output logic       o_activate,
    output logic [1:0] o_grant,
    output logic       o_busy,
    output logic       o_fault
);

    localparam int               DEB_W     = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] L_DEB     = DEB_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] L_START   = CNT_W'(START_WIN);
    localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] L_AUTO    = CNT_W'(AUTO_CLOSE_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_RUNNING,
        S_HOLD_OPEN,
        S_FAULT
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [1:0]              w_raw;
    logic [1:0][DEB_W-1:0]   r_debCnt;
    logic [1:0]              w_debLevel;
    logic [1:0]              r_debLevel;
    logic [1:0]              w_rise;
    logic [1:0]              r_pend;
    logic [1:0]              w_clrPend;
    logic [1:0]              w_btnGrant;
    logic [1:0]              w_btnClr;
    logic [1:0]              r_grant;
    logic [1:0]              w_grantNext;
    logic [CNT_W-1:0]        r_cnt;
    logic                    w_accept;
    logic                    w_unused;

    // Bit 0 is the local button, bit 1 the remote key; bit 0 also wins arbitration.
    assign w_raw      = {i_btn_remote, i_btn_local};
    assign w_rise     = w_debLevel & ~r_debLevel;
    assign w_accept   = (r_state == S_IDLE) || (r_state == S_HOLD_OPEN);
    assign w_btnGrant = r_pend[0] ? 2'b01 : 2'b10;
    assign w_btnClr   = r_pend[0] ? 2'b01 : 2'b10;

`ifdef AUTO_CLOSE_EN
    assign w_unused = i_down_max;
`else
    assign w_unused = ^{i_down_max, i_up_max, L_AUTO};
`endif

    always_comb begin
        w_debLevel = '0;
        for (int i = 0; i < 2; i++) begin
            w_debLevel[i] = (r_debCnt[i] == L_DEB);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_debCnt   <= '0;
            r_debLevel <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!w_raw[i]) begin
                    r_debCnt[i] <= '0;
                end else if (r_debCnt[i] != L_DEB) begin
                    r_debCnt[i] <= r_debCnt[i] + DEB_W'(1);
                end
            end
            r_debLevel <= w_debLevel;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_grantNext = r_grant;
        w_clrPend   = '0;
        case (r_state)
            S_IDLE: begin
                if (|r_pend) begin
                    w_stateNext = S_ISSUE;
                    w_grantNext = w_btnGrant;
                    w_clrPend   = w_btnClr;
                end
            end
            S_ISSUE: begin
                w_stateNext = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (i_up_m || i_down_m) begin
                    w_stateNext = S_RUNNING;
                end else if (r_cnt == L_START) begin
                    w_stateNext = S_FAULT;
                end
            end
            S_RUNNING: begin
                if (!i_up_m && !i_down_m) begin
`ifdef AUTO_CLOSE_EN
                    w_stateNext = i_up_max ? S_HOLD_OPEN : S_IDLE;
`else
                    w_stateNext = S_IDLE;
`endif
                end else if (r_cnt == L_TIMEOUT) begin
                    w_stateNext = S_FAULT;
                end
            end
`ifdef AUTO_CLOSE_EN
            S_HOLD_OPEN: begin
                if (|r_pend) begin
                    w_stateNext = S_ISSUE;
                    w_grantNext = w_btnGrant;
                    w_clrPend   = w_btnClr;
                end else if (r_cnt == L_AUTO) begin
                    w_stateNext = S_ISSUE;
                    w_grantNext = 2'b11;
                end
            end
`endif
            S_FAULT: begin
                w_stateNext = S_FAULT;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
        // Contradictory motor drive is fatal from any state and must not disturb the grant.
        if ((r_state != S_FAULT) && i_up_m && i_down_m) begin
            w_stateNext = S_FAULT;
            w_grantNext = r_grant;
            w_clrPend   = '0;
        end
    end

    // One shared counter: cleared on every state change, saturating so it can never wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_stateNext != r_state) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend  <= '0;
            r_grant <= 2'b00;
        end else begin
            r_grant <= w_grantNext;
            if (r_state == S_FAULT) begin
                r_pend <= '0;
            end else begin
                r_pend <= (r_pend & ~w_clrPend) | (w_accept ? w_rise : 2'b00);
            end
        end
    end

    assign o_activate = (r_state == S_ISSUE);
    assign o_grant    = r_grant;
    assign o_busy     = (r_state != S_IDLE) && (r_state != S_FAULT);
    assign o_fault    = (r_state == S_FAULT);

endmodule

// File: tb/tb_door_access_scheduler.sv
// Directed self-checking bench for door_access_scheduler; acts as button source and as a
// simple door-controller/motor model driving UP_M/DOWN_M and the end-stop sensors.
module tb_door_access_scheduler;

    logic       clk = 1'b0;
    logic       rstN;
    logic       btnLocal;
    logic       btnRemote;
    logic       upMax;
    logic       downMax;
    logic       upM;
    logic       downM;
    logic       activate;
    logic [1:0] grant;
    logic       busy;
    logic       fault;

    int testsRun    = 0;
    int testsFailed = 0;
    int actCount    = 0;

    door_access_scheduler dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_btn_local  (btnLocal),
        .i_btn_remote (btnRemote),
        .i_up_max     (upMax),
        .i_down_max   (downMax),
        .i_up_m       (upM),
        .i_down_m     (downM),
        .o_activate   (activate),
        .o_grant      (grant),
        .o_busy       (busy),
        .o_fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Every cycle advance goes through here so no Activate pulse is ever missed.
    task automatic stepCycle();
        @(negedge clk);
        if (activate === 1'b1) actCount++;
    endtask

    task automatic applyStimulus(input logic pressLocal, input logic pressRemote, input int cycles);
        btnLocal  = pressLocal;
        btnRemote = pressRemote;
        repeat (cycles) stepCycle();
        btnLocal  = 1'b0;
        btnRemote = 1'b0;
    endtask

    task automatic waitActivate(input int base);
        int n;
        n = 0;
        while (actCount == base && n < 30) begin
            stepCycle();
            n++;
        end
    endtask

    // Motor starts one cycle after Activate, runs 10 cycles, then stops at the chosen end stop.
    task automatic doTravel(input string tag, input logic useDown, input logic endUpMax);
        int busyLow;
        busyLow = 0;
        stepCycle();
        if (useDown) downM = 1'b1;
        else         upM   = 1'b1;
        upMax   = 1'b0;
        downMax = 1'b0;
        repeat (10) begin
            stepCycle();
            if (busy !== 1'b1) busyLow++;
        end
        upM     = 1'b0;
        downM   = 1'b0;
        upMax   = endUpMax;
        downMax = useDown;
        checkOutput(tag, busyLow, 0);
    endtask

    task automatic pulseReset();
        upM       = 1'b0;
        downM     = 1'b0;
        btnLocal  = 1'b0;
        btnRemote = 1'b0;
        rstN      = 1'b0;
        stepCycle();
        checkOutput("resetFault", fault, 0);
        rstN = 1'b1;
        stepCycle();
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        int base;
        int n;
        logic f4;
        logic f5;
        logic busyHold;

        rstN      = 1'b0;
        btnLocal  = 1'b0;
        btnRemote = 1'b0;
        upMax     = 1'b0;
        downMax   = 1'b1;
        upM       = 1'b0;
        downM     = 1'b0;
        repeat (3) stepCycle();
        checkOutput("rstActivate", activate, 0);
        checkOutput("rstGrant", grant, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstFault", fault, 0);
        rstN = 1'b1;
        stepCycle();

        base = actCount;
        applyStimulus(1'b1, 1'b0, 3);
        repeat (10) stepCycle();
        checkOutput("glitchAct", actCount - base, 0);
        checkOutput("glitchGrant", grant, 0);

        base = actCount;
        applyStimulus(1'b1, 1'b0, 6);
        waitActivate(base);
        checkOutput("localGrant", grant, 1);
        doTravel("localBusy", 1'b0, 1'b1);
        checkOutput("localOnePulse", actCount - base, 1);
`ifdef AUTO_CLOSE_EN
        base     = actCount;
        n        = 0;
        busyHold = 1'b0;
        while (actCount == base && n < 40) begin
            stepCycle();
            n++;
            if (n == 3) busyHold = busy;
        end
        checkOutput("holdOpenBusy", busyHold, 1);
        checkOutput("autoLatency", n, 18);
        checkOutput("autoGrant", grant, 3);
        doTravel("autoBusy", 1'b1, 1'b0);
        repeat (2) stepCycle();
        checkOutput("autoIdle", busy, 0);
`else
        base = actCount;
        repeat (40) stepCycle();
        checkOutput("noAutoAct", actCount - base, 0);
        checkOutput("noAutoBusy", busy, 0);
        checkOutput("noAutoGrant", grant, 1);
`endif

        upMax   = 1'b0;
        downMax = 1'b1;
        base    = actCount;
        applyStimulus(1'b1, 1'b1, 6);
        waitActivate(base);
        checkOutput("simulFirstGrant", grant, 1);
        doTravel("simulBusy1", 1'b0, 1'b0);
        base = actCount;
        waitActivate(base);
        checkOutput("simulSecondAct", actCount - base, 1);
        checkOutput("simulSecondGrant", grant, 2);
        doTravel("simulBusy2", 1'b1, 1'b0);
        repeat (2) stepCycle();
        checkOutput("simulIdle", busy, 0);
        checkOutput("simulOnlyTwo", actCount - base, 1);

        base = actCount;
        applyStimulus(1'b1, 1'b0, 6);
        waitActivate(base);
        f4 = 1'b0;
        f5 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            stepCycle();
            if (k == 4) f4 = fault;
            if (k == 5) f5 = fault;
        end
        checkOutput("startWinEarly", f4, 0);
        checkOutput("startWinFault", f5, 1);
        checkOutput("faultBusy", busy, 0);
        base = actCount;
        applyStimulus(1'b1, 1'b0, 6);
        repeat (10) stepCycle();
        checkOutput("faultIgnoresPress", actCount - base, 0);
        checkOutput("faultSticky", fault, 1);
        pulseReset();

        base = actCount;
        applyStimulus(1'b1, 1'b0, 6);
        waitActivate(base);
        stepCycle();
        upM = 1'b1;
        repeat (5) stepCycle();
        checkOutput("midRunBusy", busy, 1);
        rstN = 1'b0;
        #1;
        checkOutput("asyncRstBusy", busy, 0);
        checkOutput("asyncRstGrant", grant, 0);
        upM = 1'b0;
        stepCycle();
        rstN = 1'b1;
        stepCycle();

        base = actCount;
        applyStimulus(1'b1, 1'b0, 6);
        waitActivate(base);
        checkOutput("timeoutAct", actCount - base, 1);
        stepCycle();
        upM = 1'b1;
        n   = 0;
        while (fault !== 1'b1 && n < 60) begin
            stepCycle();
            n++;
        end
        checkOutput("timeoutLatency", n, 34);
        pulseReset();

        upM   = 1'b1;
        downM = 1'b1;
        stepCycle();
        checkOutput("bothMotorsFault", fault, 1);
        upM   = 1'b0;
        downM = 1'b0;
        stepCycle();
        checkOutput("bothMotorsSticky", fault, 1);
        pulseReset();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
